// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch/timer subsystem: timer states and
// the seconds-field constants used by both the up- and down-counting chains.
package stopwatch_pkg;

    localparam int SEC_W   = 6;
    localparam int SEC_MAX = 59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mmss_decrement.sv
// One-second decrement of an mm:ss value with borrow from minutes; saturates
// at 00:00. next_zero flags that the decremented value is 00:00.
module mmss_decrement
    import stopwatch_pkg::*;
#(
    parameter int MIN_W = 8
) (
    input  logic [MIN_W-1:0] minutes,
    input  logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] next_min,
    output logic [SEC_W-1:0] next_sec,
    output logic             next_zero
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_min = minutes;
        next_sec = seconds;
        if (seconds != '0) begin
            next_sec = seconds - 1'b1;
        end else if (minutes != '0) begin
            next_min = minutes - 1'b1;
            next_sec = SEC_W'(SEC_MAX);
        end
        next_zero = (next_min == '0) && (next_sec == '0);
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown timer driven by a 1 Hz tick and front-panel strobes.
// Define AUTO_RELOAD_EN to restart from the last loaded value on expiry.
module countdown_timer
    import stopwatch_pkg::*;
#(
    parameter int MIN_W   = 8,
    parameter int MAX_MIN = 99
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             clear,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    input  logic             start,
    input  logic             pause,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             done,
    output logic             expired
);

    localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);
    localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);

    state_t             state, state_next;
    logic [MIN_W-1:0]   min_next, dec_min, load_min_c, reload_min;
    logic [SEC_W-1:0]   sec_next, dec_sec, load_sec_c, reload_sec;
    logic               expired_next, dec_zero, count_zero, reload_nonzero;

    assign load_min_c = (load_min > MAX_MIN_V) ? MAX_MIN_V : load_min;
    assign load_sec_c = (load_sec > SEC_MAX_V) ? SEC_MAX_V : load_sec;
    assign count_zero = (minutes == '0) && (seconds == '0);

    mmss_decrement #(.MIN_W(MIN_W)) u_dec (
        .minutes   (minutes),
        .seconds   (seconds),
        .next_min  (dec_min),
        .next_sec  (dec_sec),
        .next_zero (dec_zero)
    );

`ifdef AUTO_RELOAD_EN
    logic load_accept;
    assign load_accept    = load && !clear && (state != RUN);
    assign reload_nonzero = (reload_min != '0) || (reload_sec != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_min <= '0;
            reload_sec <= '0;
        end else if (clear) begin
            reload_min <= '0;
            reload_sec <= '0;
        end else if (load_accept) begin
            reload_min <= load_min_c;
            reload_sec <= load_sec_c;
        end
    end
`else
    assign reload_min     = '0;
    assign reload_sec     = '0;
    assign reload_nonzero = 1'b0;
`endif

    // Strobe priority: clear > load > pause > start > tick.
    always_comb begin
        state_next   = state;
        min_next     = minutes;
        sec_next     = seconds;
        expired_next = 1'b0;
        if (clear) begin
            state_next = IDLE;
            min_next   = '0;
            sec_next   = '0;
        end else if (load && (state != RUN)) begin
            state_next = IDLE;
            min_next   = load_min_c;
            sec_next   = load_sec_c;
        end else if (pause && (state == RUN)) begin
            state_next = PAUSED;
        end else if (start && !pause && !count_zero &&
                     ((state == IDLE) || (state == PAUSED))) begin
            state_next = RUN;
        end else if (tick && (state == RUN)) begin
            min_next = dec_min;
            sec_next = dec_sec;
            if (dec_zero) begin
                expired_next = 1'b1;
                if (reload_nonzero) begin
                    min_next = reload_min;
                    sec_next = reload_sec;
                end else begin
                    state_next = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            minutes <= '0;
            seconds <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state   <= state_next;
            minutes <= min_next;
            seconds <= sec_next;
            running <= (state_next == RUN);
            done    <= (state_next == DONE);
            expired <= expired_next;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios then random
// strobes, compared against a total-seconds reference model.
module tb_countdown_timer;

    localparam int MIN_W   = 8;
    localparam int MAX_MIN = 99;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0, clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [MIN_W-1:0] load_min = '0;
    logic [5:0]       load_sec = '0;
    logic [MIN_W-1:0] minutes;
    logic [5:0]       seconds;
    logic             running, done, expired;

    int total = 0;
    int bad   = 0;

    countdown_timer #(.MIN_W(MIN_W), .MAX_MIN(MAX_MIN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .clear    (clear),
        .load     (load),
        .load_min (load_min),
        .load_sec (load_sec),
        .start    (start),
        .pause    (pause),
        .minutes  (minutes),
        .seconds  (seconds),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    // Reference model: count held as total seconds.
    typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mstate_t;
    mstate_t m_st     = M_IDLE;
    int      m_tot    = 0;
    int      m_reload = 0;
    bit      m_exp    = 1'b0;

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_tot = 0; m_reload = 0; m_exp = 1'b0;
    endtask

    task automatic model_step(bit c, bit l, int lm, int ls, bit s, bit p, bit t);
        m_exp = 1'b0;
        if (c) begin
            m_st = M_IDLE; m_tot = 0; m_reload = 0;
        end else if (l && m_st != M_RUN) begin
            m_tot    = min_i(lm, MAX_MIN) * 60 + min_i(ls, 59);
            m_reload = m_tot;
            m_st     = M_IDLE;
        end else if (p && m_st == M_RUN) begin
            m_st = M_PAUSED;
        end else if (s && !p && m_tot != 0 && (m_st == M_IDLE || m_st == M_PAUSED)) begin
            m_st = M_RUN;
        end else if (t && m_st == M_RUN) begin
            m_tot = m_tot - 1;
            if (m_tot == 0) begin
                m_exp = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (m_reload != 0) m_tot = m_reload;
                else m_st = M_DONE;
`else
                m_st = M_DONE;
`endif
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(string where);
        check({where, ".min"},     32'(minutes), 32'(m_tot / 60));
        check({where, ".sec"},     32'(seconds), 32'(m_tot % 60));
        check({where, ".running"}, 32'(running), 32'(m_st == M_RUN));
        check({where, ".done"},    32'(done),    32'(m_st == M_DONE));
        check({where, ".expired"}, 32'(expired), 32'(m_exp));
    endtask

    // One clock with the given strobes; starts and ends at a falling edge.
    task automatic cyc(string where, bit c, bit l, int lm, int ls, bit s, bit p, bit t);
        clear = c; load = l; load_min = MIN_W'(lm); load_sec = 6'(ls);
        start = s; pause = p; tick = t;
        @(posedge clk);
        model_step(c, l, int'(load_min), int'(load_sec), s, p, t);
        #1 check_all(where);
        @(negedge clk);
        clear = 0; load = 0; start = 0; pause = 0; tick = 0;
    endtask

    task automatic do_load(string w, int lm, int ls); cyc(w, 0, 1, lm, ls, 0, 0, 0); endtask
    task automatic do_start(string w);                cyc(w, 0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_tick(string w);                 cyc(w, 0, 0, 0, 0, 0, 0, 1); endtask

    initial begin
        repeat (2) @(negedge clk);
        model_reset();
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full countdown from 01:02.
        do_load("ld_0102", 1, 2);
        do_start("start_0102");
        for (int i = 0; i < 62; i++) do_tick("cd_0102");
        do_tick("tick_done");
        do_start("start_done");

        // Clamping on load, then one decrement.
        do_load("ld_clamp", 150, 75);
        do_start("start_clamp");
        do_tick("tick_clamp");

        // Pause with a coincident tick, ticks while paused, resume.
        do_load("ld_0010", 0, 10);
        do_start("start_0010");
        for (int i = 0; i < 3; i++) do_tick("cd_0010");
        cyc("pause_tick", 0, 0, 0, 0, 0, 1, 1);
        do_tick("tick_paused");
        do_tick("tick_paused");
        cyc("start_pause", 0, 0, 0, 0, 1, 1, 0);
        cyc("start_tick", 0, 0, 0, 0, 1, 0, 1);
        do_tick("tick_resume");

        // Load ignored in RUN, start ignored at 00:00, clear in PAUSED.
        do_load("ld_in_run", 5, 5);
        cyc("clear_run", 1, 0, 0, 0, 0, 0, 1);
        do_start("start_zero");
        do_load("ld_0030", 0, 30);
        do_start("start_0030");
        cyc("pause_0030", 0, 0, 0, 0, 0, 1, 0);
        cyc("clear_paused", 1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run.
        do_load("ld_0517", 5, 17);
        do_start("start_0517");
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        do_start("start_after_rst");
        do_tick("tick_after_rst");

`ifdef AUTO_RELOAD_EN
        do_load("ld_reload", 0, 2);
        do_start("start_reload");
        for (int i = 0; i < 6; i++) do_tick("cd_reload");
        cyc("clear_reload", 1, 0, 0, 0, 0, 0, 0);
        do_tick("tick_after_clear");
`endif

        // Random strobes, biased towards small load values so expiry occurs.
        for (int i = 0; i < 1500; i++) begin
            bit c, l, s, p, t;
            int lm, ls;
            c  = ($urandom % 60) == 0;
            l  = ($urandom % 15) == 0;
            s  = ($urandom % 5)  == 0;
            p  = ($urandom % 12) == 0;
            t  = ($urandom % 2)  == 0;
            lm = ($urandom % 2) ? int'($urandom % 2) : int'($urandom % 256);
            ls = ($urandom % 2) ? int'($urandom % 6) : int'($urandom % 64);
            cyc("rand", c, l, lm, ls, s, p, t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
